imem_port_arbiter: RTL
======================

Name: imem_port_arbiter

Overview:
- Shares the single-port, synchronous-read instruction memory between two requesters: the pipeline fetch stage and the program-loader/debug port.
- Loader has priority so programs can be written before or while the core runs. A burst limit bounds fetch starvation.
- Sits between the IF stage, the loader, and the instruction memory array. The memory returns read data one cycle after its enable.

Parameters:
ADDR_WIDTH, 32, byte-address width of both requesters and the memory port
DATA_WIDTH, 32, instruction/data word width
MAX_LOAD_BURST, 4, maximum consecutive loader grants while fetch is waiting (range 1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
fetch_req  in  1  fetch wants a read this cycle
fetch_addr  in  ADDR_WIDTH  fetch byte address
fetch_ready  out  1  fetch request accepted this cycle (combinational)
fetch_valid  out  1  fetch read data valid
fetch_data  out  DATA_WIDTH  fetched instruction
load_req  in  1  loader request this cycle
load_we  in  1  1 = write, 0 = read
load_addr  in  ADDR_WIDTH  loader byte address
load_wdata  in  DATA_WIDTH  loader write data
load_ready  out  1  loader request accepted this cycle (combinational)
load_valid  out  1  loader response (read data or write ack)
load_rdata  out  DATA_WIDTH  loader read data; 0 on write ack
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  word-aligned byte address to memory
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after a read with mem_en=1

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-high. All state is updated on the rising edge of clk only.
- Reset values:
  - fetch_valid=0, load_valid=0; fetch_data and load_rdata holding registers = 0.
  - Burst counter = 0; response tag = NONE.
  - While reset is high, fetch_ready=0, load_ready=0, mem_en=0 and mem_we=0.
- Grant (combinational, every cycle, reset low):
  - load_req and not (fetch_req and burst_cnt == MAX_LOAD_BURST) -> grant LOAD.
  - Otherwise fetch_req -> grant FETCH.
  - Otherwise no grant.
- Exactly one of fetch_ready or load_ready is high when granting, never both.
- Memory drive on a grant:
  - mem_en=1.
  - mem_addr = requester address with bits [1:0] forced to 0.
  - mem_we = load_we for LOAD, 0 for FETCH.
  - mem_wdata = load_wdata for LOAD, 0 otherwise.
- No grant -> mem_en=0, mem_we=0, mem_addr and mem_wdata = 0.
- Burst counter (4-bit):
  - LOAD grant while fetch_req=1 -> +1.
  - FETCH grant, or fetch_req=0 -> 0.
  - Saturates at MAX_LOAD_BURST.
- Response tag register (NONE / FETCH / LOAD_RD / LOAD_WR) is set each cycle from that cycle's grant.
- Responses, one cycle after the grant:
  - FETCH: fetch_valid=1, fetch_data=mem_rdata.
  - LOAD_RD: load_valid=1, load_rdata=mem_rdata.
  - LOAD_WR: load_valid=1, load_rdata=0.
- Outside a valid cycle, fetch_data and load_rdata hold their last delivered value. Holding registers capture on valid.
- Throughput: one access per cycle, back-to-back grants allowed. Read latency is exactly 1 cycle from ready to valid.
- Requester rules:
  - A requester keeps req and addr stable until it sees ready.
  - Dropping req without ready is legal; no access occurs.
- Same address, loader write then fetch read on the next cycle: fetch returns the new data (the memory is write-before-next-read).
- Reset mid-operation: a grant issued in the cycle before reset produces no valid after reset. Tag and counter return to reset values.
- Misaligned addresses are not an error. Low bits are dropped silently.

Test Plan:
- Reset for 2 cycles, then fetch_req=1 at addr 0x8 with memory word 2 = 0x00500113 -> fetch_ready=1 at cycle t; fetch_valid=1 and fetch_data=0x00500113 at t+1; load_valid=0 throughout.
- Loader writes 0x00A20093 to addr 0x18 (load_we=1), then fetch reads 0x18 -> load_valid=1 with load_rdata=0 at t+1; next fetch returns 0x00A20093.
- fetch_req and load_req both held high for 12 cycles, MAX_LOAD_BURST=4 -> grant sequence is L,L,L,L,F,L,L,L,L,F,L,L; every response appears exactly 1 cycle after its grant.
- Fetch streams addrs 0x0, 0x4, 0x8, 0xC with no loader -> 4 consecutive fetch_valid cycles; data equals words 0..3 in order; fetch_data holds word 3 after the stream.
- Fetch granted at cycle t, reset asserted at t+1 -> fetch_valid=0 at t+1 and t+2; mem_en=0 while reset is high; counter=0 afterwards.
- Fetch addr 0x7 with memory word 1 = 0xDEADBEEF -> mem_addr=0x4; fetch_data=0xDEADBEEF.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// Arbitrates one single-port, synchronous-read instruction memory between fetch and loader.
// The loader wins by default; fetch is forced through after MAX_LOAD_BURST loader grants.
module imem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_LOAD_BURST = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  fetch_req_i,
    input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
    output logic                  fetch_ready_o,
    output logic                  fetch_valid_o,
    output logic [DATA_WIDTH-1:0] fetch_data_o,
    input  logic                  load_req_i,
    input  logic                  load_we_i,
    input  logic [ADDR_WIDTH-1:0] load_addr_i,
    input  logic [DATA_WIDTH-1:0] load_wdata_i,
    output logic                  load_ready_o,
    output logic                  load_valid_o,
    output logic [DATA_WIDTH-1:0] load_rdata_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {TAG_NONE, TAG_FETCH, TAG_LOAD_RD, TAG_LOAD_WR} tag_e;

    localparam logic [3:0]            BURST_MAX  = 4'(MAX_LOAD_BURST);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    tag_e                  tag_q, tag_d;
    logic [3:0]            burst_q, burst_d;
    logic [DATA_WIDTH-1:0] fetch_hold_q, load_hold_q;
    logic                  grant_load, grant_fetch;

    always_comb begin
        grant_load  = 1'b0;
        grant_fetch = 1'b0;
        if (!reset_i) begin
            grant_load  = load_req_i && !(fetch_req_i && burst_q == BURST_MAX);
            grant_fetch = !grant_load && fetch_req_i;
        end
    end

    assign fetch_ready_o = grant_fetch;
    assign load_ready_o  = grant_load;

    always_comb begin
        mem_en_o    = grant_load || grant_fetch;
        mem_we_o    = grant_load && load_we_i;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (grant_load) begin
            mem_addr_o  = load_addr_i & ALIGN_MASK;
            mem_wdata_o = load_wdata_i;
        end else if (grant_fetch) begin
            mem_addr_o  = fetch_addr_i & ALIGN_MASK;
        end
    end

    // Counts loader wins only while fetch is actually waiting.
    always_comb begin
        burst_d = '0;
        if (grant_load && fetch_req_i)
            burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + 4'd1;
    end

    always_comb begin
        tag_d = TAG_NONE;
        if (grant_fetch)
            tag_d = TAG_FETCH;
        else if (grant_load)
            tag_d = load_we_i ? TAG_LOAD_WR : TAG_LOAD_RD;
    end

    // Responses are gated by reset so a grant just before reset never completes.
    assign fetch_valid_o = !reset_i && (tag_q == TAG_FETCH);
    assign load_valid_o  = !reset_i && (tag_q == TAG_LOAD_RD || tag_q == TAG_LOAD_WR);
    assign fetch_data_o  = fetch_valid_o ? mem_rdata_i : fetch_hold_q;
    assign load_rdata_o  = load_valid_o ? ((tag_q == TAG_LOAD_RD) ? mem_rdata_i : '0)
                                        : load_hold_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tag_q        <= TAG_NONE;
            burst_q      <= '0;
            fetch_hold_q <= '0;
            load_hold_q  <= '0;
        end else begin
            tag_q   <= tag_d;
            burst_q <= burst_d;
            if (fetch_valid_o) fetch_hold_q <= fetch_data_o;
            if (load_valid_o)  load_hold_q  <= load_rdata_o;
        end
    end

endmodule
